// File: rtl/mem_arb_pkg.sv
// Shared types for the byte-serial memory port arbiter: FSM states, requester IDs, access sizes
// and the load-extension helper used when assembling read data.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_TRI  = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   // raw holds the assembled bytes right-justified; the upper bytes are already zero
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [1:0]  size,
                                               input logic        sext);
      logic [31:0] res;
      res = raw;
      case (size)
         SZ_BYTE: res = {{24{sext & raw[7]}},  raw[7:0]};
         SZ_HALF: res = {{16{sext & raw[15]}}, raw[15:0]};
         SZ_TRI:  res = {{8{sext & raw[23]}},  raw[23:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Latches one granted access and walks it byte by byte, MSB first; one byte per active cycle.
// No backpressure: the memory answers combinationally, so every active cycle completes a byte.
module mem_byte_sequencer
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              active,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [1:0]        op_size,
   input  logic              op_we,
   input  logic [31:0]       op_wdata,
   input  logic              op_sext,
   input  logic [7:0]        mem_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic              last,
   output logic              lat_we,
   output logic [31:0]       rdata
);

   logic [ADDR_W-1:0] base_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic              sext_q;
   logic [1:0]        cnt_q;
   logic [31:0]       acc_q;
   logic [31:0]       acc_nxt;
   logic [1:0]        byte_sel;

   assign acc_nxt  = {acc_q[23:0], mem_rdata};
   assign byte_sel = size_q - cnt_q;
   assign last     = (cnt_q == size_q);
   assign lat_we   = we_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_q  <= '0;
         size_q  <= SZ_BYTE;
         we_q    <= 1'b0;
         wdata_q <= '0;
         sext_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else if (start) begin
         base_q  <= op_addr;
         size_q  <= op_size;
         we_q    <= op_we;
         wdata_q <= op_wdata;
         sext_q  <= op_sext;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else if (active) begin
         if (!we_q) begin
            acc_q <= acc_nxt;
         end
         if (!last) begin
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

   // Memory-side outputs are gated by the live FSM state so an async reset drops them at once
   always_comb begin
      mem_en    = active;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (active) begin
         mem_addr = base_q + ADDR_W'(cnt_q);
         mem_we   = we_q;
         if (we_q) begin
            mem_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
         end
      end
   end

   // Includes the byte being read this cycle so the final value is ready at the last edge
   assign rdata = extend_load(acc_nxt, size_q, sext_q);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between fetch and load/store.
// Latency size+2 cycles from request to done pulse; a losing requester simply waits holding req.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic [1:0]        if_size,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [1:0]        ls_size,
   input  logic              ls_sign_extend,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   state_t            state_q;
   state_t            state_d;
   req_id_t           last_grant;
   req_id_t           grant_d;
   logic              start;
   logic              seq_last;
   logic              seq_we;
   logic [31:0]       seq_rdata;
   logic [ADDR_W-1:0] op_addr;
   logic [1:0]        op_size;
   logic              op_we;
   logic [31:0]       op_wdata;
   logic              op_sext;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = last_grant;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || ls_req) begin
               start   = 1'b1;
               state_d = XFER;
               // On a tie the port that did not go last wins
               if (if_req && ls_req) begin
                  grant_d = (last_grant == REQ_IF) ? REQ_LS : REQ_IF;
               end else if (if_req) begin
                  grant_d = REQ_IF;
               end else begin
                  grant_d = REQ_LS;
               end
            end
         end
         XFER: begin
            if (seq_last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_addr  = if_addr;
      op_size  = if_size;
      op_we    = 1'b0;
      op_wdata = '0;
      op_sext  = 1'b0;
      if (grant_d == REQ_LS) begin
         op_addr  = ls_addr;
         op_size  = ls_size;
         op_we    = ls_we;
         op_wdata = ls_wdata;
         op_sext  = ls_sign_extend;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= REQ_LS;
         if_rdata   <= '0;
         ls_rdata   <= '0;
      end else begin
         if (start) begin
            last_grant <= grant_d;
         end
         if (state_q == XFER && seq_last) begin
            if (last_grant == REQ_IF) begin
               if_rdata <= seq_rdata;
            end else if (!seq_we) begin
               ls_rdata <= seq_rdata;
            end
         end
      end
   end

   assign if_done = (state_q == DONE) && (last_grant == REQ_IF);
   assign ls_done = (state_q == DONE) && (last_grant == REQ_LS);
   assign busy    = (state_q != IDLE);

   mem_byte_sequencer #(
      .ADDR_W (ADDR_W)
   ) u_seq (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .active    (state_q == XFER),
      .op_addr   (op_addr),
      .op_size   (op_size),
      .op_we     (op_we),
      .op_wdata  (op_wdata),
      .op_sext   (op_sext),
      .mem_rdata (mem_rdata),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .last      (seq_last),
      .lat_we    (seq_we),
      .rdata     (seq_rdata)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a 256-byte memory model and
// a byte-level reference model of every access.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [1:0]  if_size;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [1:0]  ls_size;
   logic        ls_sign_extend;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   int checks;
   int errors;
   logic [7:0]  mem [0:255];
   logic [7:0]  ref_mem [0:255];
   bit          mem_init_done;
   logic [31:0] exp_if_rdata;
   logic [31:0] exp_ls_rdata;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_size        (if_size),
      .if_done        (if_done),
      .if_rdata       (if_rdata),
      .ls_req         (ls_req),
      .ls_we          (ls_we),
      .ls_addr        (ls_addr),
      .ls_size        (ls_size),
      .ls_sign_extend (ls_sign_extend),
      .ls_wdata       (ls_wdata),
      .ls_done        (ls_done),
      .ls_rdata       (ls_rdata),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .busy           (busy)
   );

   function automatic logic [7:0] preload_val(input int i);
      case (i)
         16'h10:  return 8'h81;
         16'h11:  return 8'h22;
         16'h12:  return 8'h33;
         16'h13:  return 8'h44;
         default: return 8'((i * 37 + 11) & 255);
      endcase
   endfunction

   // Byte memory: combinational read, write on the clock edge, filled once during the first reset
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clock) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= preload_val(i);
         mem_init_done <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: reads assemble big-endian with arithmetic sign extension; stores update ref_mem
   function automatic logic [31:0] model_access(input bit is_if, input bit we,
                                                input logic [31:0] addr, input logic [1:0] size,
                                                input bit sext, input logic [31:0] wdata);
      logic [31:0] val;
      int nb;
      logic [31:0] a;
      val = 0;
      nb  = int'(size) + 1;
      for (int j = 0; j < nb; j++) begin
         a = addr + 32'(j);
         if (!is_if && we) ref_mem[a[7:0]] = 8'((wdata >> (8 * (nb - 1 - j))) & 32'hFF);
         else val = (val << 8) | 32'(ref_mem[a[7:0]]);
      end
      if (!is_if && !we && sext && nb < 4 && ((val >> (8 * nb - 1)) & 32'd1) == 32'd1)
         val = val - (32'd1 << (8 * nb));
      return val;
   endfunction

   task automatic xact(input bit is_if, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit sext, input logic [31:0] wdata,
                       input bit scramble);
      logic [31:0] exp_data;
      int nb;
      nb = int'(size) + 1;
      @(negedge clock);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_en", 32'(mem_en), 32'd0);
      if (is_if) begin
         if_req = 1'b1; if_addr = addr; if_size = size;
      end else begin
         ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_size = size;
         ls_sign_extend = sext; ls_wdata = wdata;
      end
      exp_data = model_access(is_if, we, addr, size, sext, wdata);
      for (int i = 0; i < nb; i++) begin
         @(negedge clock);
         chk("xfer_en", 32'(mem_en), 32'd1);
         chk("xfer_addr", mem_addr, addr + 32'(i));
         chk("xfer_we", 32'(mem_we), 32'(!is_if && we));
         if (!is_if && we)
            chk("xfer_wdata", 32'(mem_wdata), (wdata >> (8 * (nb - 1 - i))) & 32'hFF);
         chk("xfer_nodone", {30'd0, if_done, ls_done}, 32'd0);
         chk("xfer_busy", 32'(busy), 32'd1);
         if (scramble && i == 0) begin
            if_addr = $urandom; if_size = 2'($urandom);
            ls_addr = $urandom; ls_size = 2'($urandom); ls_we = 1'($urandom);
            ls_sign_extend = 1'($urandom); ls_wdata = $urandom;
         end
      end
      @(negedge clock);
      chk("done_pulse", {30'd0, if_done, ls_done}, is_if ? 32'd2 : 32'd1);
      chk("done_en", 32'(mem_en), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      if (is_if) exp_if_rdata = exp_data;
      else if (!we) exp_ls_rdata = exp_data;
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("ls_rdata", ls_rdata, exp_ls_rdata);
      if_req = 1'b0;
      ls_req = 1'b0;
   endtask

   initial begin
      bit          exp_ifd [0:12];
      bit          exp_lsd [0:12];
      int          t;
      bit          nxt_if;
      logic [31:0] arb_if_data;
      logic [31:0] arb_ls_data;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = preload_val(i);
      exp_if_rdata = 0;
      exp_ls_rdata = 0;

      // Reset with both requesters already asking
      reset_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h12; if_size = 2'd0;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; ls_size = 2'd0;
      ls_sign_extend = 1'b1; ls_wdata = 32'h0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", {30'd0, if_done, ls_done}, 32'd0);
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);

      // Round-robin schedule: each access is sampled, takes size+1 bytes, done, then re-sampled
      for (int k = 0; k <= 12; k++) begin exp_ifd[k] = 0; exp_lsd[k] = 0; end
      t = 0;
      nxt_if = 1'b1;
      while (t <= 12) begin
         if (t + 2 <= 12) begin
            if (nxt_if) exp_ifd[t + 2] = 1'b1;
            else exp_lsd[t + 2] = 1'b1;
         end
         t = t + 3;
         nxt_if = !nxt_if;
      end
      arb_if_data = model_access(1'b1, 1'b0, 32'h12, 2'd0, 1'b0, 32'h0);
      arb_ls_data = model_access(1'b0, 1'b0, 32'h10, 2'd0, 1'b1, 32'h0);
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         chk("arb_if_done", 32'(if_done), 32'(exp_ifd[k]));
         chk("arb_ls_done", 32'(ls_done), 32'(exp_lsd[k]));
         if (exp_ifd[k]) chk("arb_if_rdata", if_rdata, arb_if_data);
         if (exp_lsd[k]) chk("arb_ls_rdata", ls_rdata, arb_ls_data);
      end
      chk("arb_if_const", if_rdata, 32'h00000033);
      chk("arb_ls_const", ls_rdata, 32'hFFFFFF81);

      if_req = 1'b0;
      ls_req = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      exp_if_rdata = 0;
      exp_ls_rdata = 0;

      // Directed loads from the preloaded 81 22 33 44 window
      xact(1'b0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 1'b0);
      chk("ld_word", ls_rdata, 32'h81223344);
      xact(1'b0, 1'b0, 32'h10, 2'd0, 1'b1, 32'h0, 1'b0);
      chk("ld_byte_sx", ls_rdata, 32'hFFFFFF81);
      xact(1'b0, 1'b0, 32'h10, 2'd0, 1'b0, 32'h0, 1'b0);
      chk("ld_byte_zx", ls_rdata, 32'h00000081);
      xact(1'b0, 1'b0, 32'h10, 2'd1, 1'b1, 32'h0, 1'b0);
      chk("ld_half_sx", ls_rdata, 32'hFFFF8122);
      xact(1'b0, 1'b0, 32'h11, 2'd2, 1'b1, 32'h0, 1'b0);
      chk("ld_tri_sx", ls_rdata, 32'h00223344);

      // Store then read back; the store must not disturb ls_rdata
      xact(1'b0, 1'b1, 32'h04, 2'd1, 1'b0, 32'h0000BEEF, 1'b0);
      chk("st_keep_rdata", ls_rdata, 32'h00223344);
      chk("st_mem4", 32'(mem[4]), 32'hBE);
      chk("st_mem5", 32'(mem[5]), 32'hEF);
      xact(1'b0, 1'b0, 32'h04, 2'd1, 1'b0, 32'h0, 1'b0);
      chk("st_readback", ls_rdata, 32'h0000BEEF);

      // Fetch wrapping past the top of the address space
      xact(1'b1, 1'b0, 32'hFFFFFFFE, 2'd3, 1'b0, 32'h0, 1'b0);
      chk("if_wrap", if_rdata, 32'hC1E60B30);

      // Random accesses with operands scrambled after grant
      for (int r = 0; r < 60; r++) begin
         bit          r_if;
         bit          r_we;
         logic [31:0] r_addr;
         r_if = ($urandom_range(0, 3) == 0);
         r_we = !r_if && 1'($urandom);
         r_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                              : 32'h20 + 32'($urandom_range(0, 31));
         xact(r_if, r_we, r_addr, 2'($urandom), 1'($urandom), $urandom, 1'b1);
      end

      // Reset during a 4-byte store once two bytes have landed
      begin
         logic [7:0] old2;
         logic [7:0] old3;
         old2 = ref_mem[2];
         old3 = ref_mem[3];
         @(negedge clock);
         ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0; ls_size = 2'd3;
         ls_sign_extend = 1'b0; ls_wdata = 32'hA1B2C3D4;
         repeat (2) @(negedge clock);
         chk("abort_we_before", 32'(mem_we), 32'd1);
         @(negedge clock);
         reset_n = 1'b0;
         ls_req = 1'b0;
         #1;
         chk("abort_we", 32'(mem_we), 32'd0);
         chk("abort_en", 32'(mem_en), 32'd0);
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_done", 32'(ls_done), 32'd0);
         repeat (2) begin
            @(negedge clock);
            chk("abort_nodone", {30'd0, if_done, ls_done}, 32'd0);
         end
         chk("abort_mem0", 32'(mem[0]), 32'hA1);
         chk("abort_mem1", 32'(mem[1]), 32'hB2);
         chk("abort_mem2", 32'(mem[2]), 32'(old2));
         chk("abort_mem3", 32'(mem[3]), 32'(old3));
         chk("abort_ls_rdata", ls_rdata, 32'd0);
         ref_mem[0] = 8'hA1;
         ref_mem[1] = 8'hB2;
         reset_n = 1'b1;
         exp_if_rdata = 0;
         exp_ls_rdata = 0;
         xact(1'b0, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
